// File: rtl/hs_push_bridge.sv
// hs_push_bridge: clocked valid/ready producer -> 4-phase bundled-data push.
// Words are buffered in a FIFO and issued one at a time as req/ack
// return-to-zero handshakes toward an async join input.
//
// Parameters:
//   DATA_W       payload width
//   DEPTH        FIFO entries (power of 2, >= 2)
//   SYNC_STAGES  ack_out_i synchroniser depth (>= 2)
//   TIMEOUT_CYC  wait-state cycles before err_timeout_o sets
//
// Ports:
//   clk_i, rst_ni       clock; synchronous active-low reset
//   valid_i, ready_o    producer handshake (ready_o = FIFO not full)
//   data_i              producer word
//   req_out_o           registered 4-phase request
//   ack_out_i           asynchronous 4-phase acknowledge
//   data_out_o          registered bundled data, stable while req high
//   level_o             FIFO occupancy 0..DEPTH
//   busy_o              handshake FSM not idle
//   err_timeout_o       sticky handshake timeout flag
//
// Optional feature: define HS_PUSH_BRIDGE_TIMEOUT_EN to build the
// handshake timeout counter; otherwise err_timeout_o is tied low.

module hs_push_bridge #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DATA_W-1:0]          data_i,
    output logic                       req_out_o,
    input  logic                       ack_out_i,
    output logic [DATA_W-1:0]          data_out_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       busy_o,
    output logic                       err_timeout_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_REQ_HI,
        S_REQ_LO
    } state_t;

    logic [DATA_W-1:0]      r_mem [DEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [LW-1:0]          r_level;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req;
    logic [DATA_W-1:0]      r_dout;
    state_t                 r_state;
    state_t                 w_state_nx;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ack_s;
    logic                   w_have;

    // ready depends only on the registered level, never on a same-cycle pop
    assign ready_o    = (r_level != LW'(DEPTH));
    assign w_push     = valid_i & ready_o;
    assign w_have     = (r_level != '0);
    assign w_ack_s    = r_sync[SYNC_STAGES-1];
    assign req_out_o  = r_req;
    assign data_out_o = r_dout;
    assign level_o    = r_level;
    assign busy_o     = (r_state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ack_out_i};
        end
    end

    // Pops happen only from IDLE or REQ_LO with ack_s low, i.e. while req is
    // low, so data_out_o never changes under a raised request.
    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_have && !w_ack_s) begin
                    w_state_nx = S_SETUP;
                    w_pop      = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_nx = S_REQ_HI;
            end
            S_REQ_HI: begin
                if (w_ack_s) begin
                    w_state_nx = S_REQ_LO;
                end
            end
            S_REQ_LO: begin
                if (!w_ack_s) begin
                    if (w_have) begin
                        w_state_nx = S_SETUP;
                        w_pop      = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_req   <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_req   <= (w_state_nx == S_REQ_HI);
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
                r_dout <= r_mem[r_rptr];
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

`ifdef HS_PUSH_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_tcnt;
    logic [TW-1:0] w_tcnt_nx;
    logic          r_err;
    logic          w_wait;
    logic          w_enter;

    assign w_wait  = (r_state == S_REQ_HI) || (r_state == S_REQ_LO);
    assign w_enter = (w_state_nx != r_state) &&
                     ((w_state_nx == S_REQ_HI) || (w_state_nx == S_REQ_LO));

    always_comb begin
        w_tcnt_nx = r_tcnt;
        if (w_enter) begin
            w_tcnt_nx = '0;
        end else if (w_wait && (r_tcnt != TW'(TIMEOUT_CYC))) begin
            w_tcnt_nx = r_tcnt + TW'(1);
        end
    end

    // Flag only; the handshake keeps waiting for ack
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_tcnt <= w_tcnt_nx;
            if (w_tcnt_nx == TW'(TIMEOUT_CYC)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_timeout_o = r_err;
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule
